// File: rtl/ma_engine_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ma_engine_arbiter_if
// Purpose  : Bundles the requester, engine and result signals of the
//            moving-average engine arbiter.
//            slave  - the arbiter side (accepts requests, drives the engine,
//                     returns results).
//            master - the environment side (requesters, engine, result sink).
// Signals  : req_valid/req_data/req_ready   per-channel sample handshake
//            eng_start/eng_ch/eng_data      issue to the shared engine
//            eng_done/eng_result            engine completion
//            res_valid/res_ch/res_data      tagged result strobe
//            timeout_err/timeout_cnt/busy   status
// Revision : 1.0 - initial release
// ============================================================================
interface ma_engine_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    localparam int c_ch_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]        req_valid;
    logic [NUM_CH*DATA_W-1:0] req_data;
    logic [NUM_CH-1:0]        req_ready;
    logic                     eng_start;
    logic [c_ch_w-1:0]        eng_ch;
    logic [DATA_W-1:0]        eng_data;
    logic                     eng_done;
    logic [DATA_W-1:0]        eng_result;
    logic                     res_valid;
    logic [c_ch_w-1:0]        res_ch;
    logic [DATA_W-1:0]        res_data;
    logic                     timeout_err;
    logic [7:0]               timeout_cnt;
    logic                     busy;

    modport slave (
        input  req_valid, req_data, eng_done, eng_result,
        output req_ready, eng_start, eng_ch, eng_data,
               res_valid, res_ch, res_data, timeout_err, timeout_cnt, busy
    );

    modport master (
        output req_valid, req_data, eng_done, eng_result,
        input  req_ready, eng_start, eng_ch, eng_data,
               res_valid, res_ch, res_data, timeout_err, timeout_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/ma_engine_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ma_engine_arbiter
// Purpose  : Time-multiplexes one moving-average engine across NUM_CH
//            price-feed channels. Channels are granted round-robin, one
//            sample per grant is issued to the engine, and the engine result
//            is returned tagged with its channel. A hung engine is aborted
//            after TIMEOUT wait cycles.
// Ports    : clk  - system clock (rising edge)
//            rst  - synchronous active-high reset
//            bus  - ma_engine_arbiter_if.slave (requests, engine, results,
//                   status)
// Revision : 1.0 - initial release
// ============================================================================
module ma_engine_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input wire clk,
    input wire rst,
    ma_engine_arbiter_if.slave bus
);
    localparam int c_ch_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT) + 1;
    localparam logic [c_cnt_w-1:0] c_to_last = c_cnt_w'(TIMEOUT - 1);

    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_issue   = 2'd1;
    localparam logic [1:0] c_wait    = 2'd2;
    localparam logic [1:0] c_deliver = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_ch_w-1:0]  r_rr_ptr;
    logic [c_ch_w-1:0]  r_ch;
    logic [DATA_W-1:0]  r_data;
    logic [c_cnt_w-1:0] r_wait_cnt;
    logic [c_ch_w-1:0]  r_res_ch;
    logic [DATA_W-1:0]  r_res_data;
    logic               r_timeout_err;
    logic [7:0]         r_timeout_cnt;

    logic [NUM_CH-1:0]  w_gnt_oh;
    logic               w_gnt_any;
    logic [c_ch_w-1:0]  w_gnt_ch;
    logic [DATA_W-1:0]  w_gnt_data;
    logic [c_ch_w-1:0]  w_next_ptr;
    logic               w_transfer;
    logic               w_timeout_hit;

    logic [NUM_CH-1:0]  w_req_ready;
    logic               w_eng_start;
    logic               w_res_valid;
    logic               w_busy;

    // Round-robin search: first asserted request at or above r_rr_ptr,
    // wrapping past NUM_CH-1 back to channel 0.
    always_comb begin : p_grant
        int idx;
        w_gnt_oh   = '0;
        w_gnt_any  = 1'b0;
        w_gnt_ch   = '0;
        w_gnt_data = '0;
        w_next_ptr = '0;
        idx        = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!w_gnt_any && bus.req_valid[idx]) begin
                w_gnt_any     = 1'b1;
                w_gnt_oh[idx] = 1'b1;
                w_gnt_ch      = c_ch_w'(idx);
                w_gnt_data    = bus.req_data[idx*DATA_W +: DATA_W];
                w_next_ptr    = (idx == NUM_CH - 1) ? '0 : c_ch_w'(idx + 1);
            end
        end
    end

    assign w_transfer    = (r_state == c_idle) && w_gnt_any;
    assign w_timeout_hit = (r_wait_cnt == c_to_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; eng_done takes priority over a coincident timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle: begin
                if (w_gnt_any) begin
                    w_next_state = c_issue;
                end
            end
            c_issue: begin
                w_next_state = c_wait;
            end
            c_wait: begin
                if (bus.eng_done) begin
                    w_next_state = c_deliver;
                end else if (w_timeout_hit) begin
                    w_next_state = c_idle;
                end
            end
            c_deliver: begin
                w_next_state = c_idle;
            end
            default: begin
                w_next_state = c_idle;
            end
        endcase
    end

    // State-decoded outputs; grants are only offered while idle.
    always_comb begin
        w_req_ready = '0;
        w_eng_start = 1'b0;
        w_res_valid = 1'b0;
        w_busy      = (r_state != c_idle);
        case (r_state)
            c_idle:    w_req_ready = w_gnt_oh;
            c_issue:   w_eng_start = 1'b1;
            c_deliver: w_res_valid = 1'b1;
            default:   ;
        endcase
    end

    // Datapath: channel/sample latches, wait counter, result and abort status.
    // The sample latch loads at the grant edge, so eng_ch/eng_data become
    // valid in ISSUE and stay put until the following issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr      <= '0;
            r_ch          <= '0;
            r_data        <= '0;
            r_wait_cnt    <= '0;
            r_res_ch      <= '0;
            r_res_data    <= '0;
            r_timeout_err <= 1'b0;
            r_timeout_cnt <= '0;
        end else begin
            r_timeout_err <= 1'b0;
            if (w_transfer) begin
                r_ch     <= w_gnt_ch;
                r_data   <= w_gnt_data;
                r_rr_ptr <= w_next_ptr;
            end
            case (r_state)
                c_issue: begin
                    r_wait_cnt <= '0;
                end
                c_wait: begin
                    r_wait_cnt <= r_wait_cnt + c_cnt_w'(1);
                    if (bus.eng_done) begin
                        r_res_ch   <= r_ch;
                        r_res_data <= bus.eng_result;
                    end else if (w_timeout_hit) begin
                        r_timeout_err <= 1'b1;
                        if (r_timeout_cnt != 8'hFF) begin
                            r_timeout_cnt <= r_timeout_cnt + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.eng_start   = w_eng_start;
    assign bus.eng_ch      = r_ch;
    assign bus.eng_data    = r_data;
    assign bus.res_valid   = w_res_valid;
    assign bus.res_ch      = r_res_ch;
    assign bus.res_data    = r_res_data;
    assign bus.timeout_err = r_timeout_err;
    assign bus.timeout_cnt = r_timeout_cnt;
    assign bus.busy        = w_busy;
endmodule
`default_nettype wire
